// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state codes, datapath mux codes and terminal-count bit for the CORDIC controller
package cordic_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ITER_ROT = 3'd2,
    ITER_VEC = 3'd3,
    DONE     = 3'd4
  } state_t;
  localparam logic [1:0] MUX_HOLD = 2'b00;
  localparam logic [1:0] MUX_LOAD = 2'b01;
  localparam logic [1:0] MUX_ROT  = 2'b10;
  localparam logic [1:0] MUX_VEC  = 2'b11;
  localparam int TERM_BIT = 3;
  localparam logic [3:0] TERM_COUNT = 4'(1 << TERM_BIT);
endpackage

// File: rtl/cordic_fsm_ctl.sv
// cordic_fsm_ctl: Moore controller sequencing load, rotation/vectoring iterations and done for a CORDIC datapath
module cordic_fsm_ctl
  import cordic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       cordic_mode,
  input  logic [3:0] counter,
  output logic [2:0] state,
  output logic [1:0] in_mux_ctl,
  output logic       counter_rst,
  output logic       counter_hold
);
  state_t cur, nxt;
  logic mode;
  // counter >= 2**TERM_BIT is exactly counter[TERM_BIT] set for a 4-bit count
  logic term;
  assign term = counter >= TERM_COUNT;
  assign state = cur;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur  <= IDLE;
      mode <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == IDLE && start) mode <= cordic_mode;
    end
  end
  always_comb begin
    nxt = IDLE;
    case (cur)
      IDLE:               nxt = start ? LOAD : IDLE;
      LOAD:               nxt = mode ? ITER_VEC : ITER_ROT;
      ITER_ROT, ITER_VEC: nxt = term ? DONE : cur;
      default:            nxt = IDLE;
    endcase
  end
  always_comb begin
    in_mux_ctl   = cur == LOAD ? MUX_LOAD : cur == ITER_ROT ? MUX_ROT : cur == ITER_VEC ? MUX_VEC : MUX_HOLD;
    counter_rst  = cur == LOAD || !(cur == ITER_ROT || cur == ITER_VEC || cur == DONE);
    counter_hold = !(cur == ITER_ROT || cur == ITER_VEC);
  end
endmodule

// File: tb/tb_cordic_fsm_ctl.sv
// tb_cordic_fsm_ctl: randomized and directed checks of cordic_fsm_ctl against a behavioural model
module tb_cordic_fsm_ctl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, cordic_mode = 1'b0;
  logic [3:0] counter = 4'd0;
  logic [2:0] state;
  logic [1:0] in_mux_ctl;
  logic counter_rst, counter_hold;
  logic [6:0] obs;
  int checks = 0, errors = 0;
  int m_state = 0;
  bit m_mode = 0;

  cordic_fsm_ctl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cordic_mode(cordic_mode),
    .counter(counter), .state(state), .in_mux_ctl(in_mux_ctl),
    .counter_rst(counter_rst), .counter_hold(counter_hold)
  );

  always #5 clk = ~clk;
  assign obs = {state, in_mux_ctl, counter_rst, counter_hold};

  // Expected outputs straight from the phase: load/rot/vec select, clear before iterating, run only while iterating
  function automatic logic [6:0] exp_vec(int s);
    logic [1:0] mux;
    mux = s == 1 ? 2'b01 : s == 2 ? 2'b10 : s == 3 ? 2'b11 : 2'b00;
    return {3'(s), mux, 1'(s <= 1), 1'(s != 2 && s != 3)};
  endfunction

  task automatic tick(input bit rn, input bit st, input bit cm, input logic [3:0] cnt);
    reset_n = rn; start = st; cordic_mode = cm; counter = cnt;
    @(posedge clk);
    if (!rn) begin
      m_state = 0; m_mode = 0;
    end else if (m_state == 0) begin
      if (st) begin m_mode = cm; m_state = 1; end
    end else if (m_state == 1) m_state = m_mode ? 3 : 2;
    else if (m_state == 2 || m_state == 3) begin
      if (cnt >= 8) m_state = 4;
    end else m_state = 0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1'($urandom), 1'($urandom), 4'($urandom));
      checks++;
      if (obs !== 7'b000_00_1_1 || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL reset %0d: got %b want 0000011", i, obs);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] cnt [7] = '{0, 0, 1, 2, 3, 8, 0};
    bit st [7] = '{1, 0, 0, 0, 0, 0, 0};
    int want [7] = '{1, 2, 2, 2, 2, 4, 0};
    tick(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(1, st[i], 0, cnt[i]);
      checks++;
      if (state !== 3'(want[i]) || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL rotation step %0d: got %b want state %0d vec %b", i, obs, want[i], exp_vec(m_state));
      end
    end
  endtask

  task automatic test_vectoring();
    logic [3:0] cnt [7] = '{0, 0, 2, 4, 6, 8, 0};
    bit st [7] = '{1, 0, 0, 0, 0, 0, 0};
    int want [7] = '{1, 3, 3, 3, 3, 4, 0};
    tick(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(1, st[i], 1, cnt[i]);
      checks++;
      if (state !== 3'(want[i]) || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL vectoring step %0d: got %b want state %0d vec %b", i, obs, want[i], exp_vec(m_state));
      end
    end
  endtask

  task automatic test_mode_change();
    logic [3:0] cnt [5] = '{0, 0, 3, 8, 0};
    bit st [5] = '{1, 0, 1, 1, 0};
    bit cm [5] = '{0, 1, 1, 1, 1};
    int want [5] = '{1, 2, 2, 4, 0};
    tick(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, st[i], cm[i], cnt[i]);
      checks++;
      if (state !== 3'(want[i]) || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL mode_change step %0d: got %b want state %0d", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cnt [6] = '{0, 0, 0, 9, 0, 0};
    int want [6] = '{1, 3, 3, 4, 0, 1};
    tick(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 1, cnt[i]);
      checks++;
      if (state !== 3'(want[i]) || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b want state %0d", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit rn [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    bit st [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    bit cm [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    logic [3:0] cnt [8] = '{0, 0, 5, 5, 0, 0, 12, 0};
    int want [8] = '{1, 3, 3, 0, 1, 2, 4, 0};
    tick(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(rn[i], st[i], cm[i], cnt[i]);
      checks++;
      if (state !== 3'(want[i]) || obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %b want state %0d", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_random();
    tick(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 24) != 0), 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 3) == 0 ? $urandom_range(8, 15) : $urandom_range(0, 7)));
      checks++;
      if (obs !== exp_vec(m_state)) begin
        errors++;
        $display("FAIL random step %0d: got %b want %b", i, obs, exp_vec(m_state));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_mode_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_fsm_ctl.md
CORDIC_FSM_CTL -- requirements
Module: cordic_fsm_ctl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset_n, input, 1 bit: synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port start, input, 1 bit: request to begin one CORDIC operation; level-sampled.
REQ-005 Port cordic_mode, input, 1 bit: 0 = rotation, 1 = vectoring.
REQ-006 Port counter, input, 4 bits: current iteration count from the external iteration counter.
REQ-007 Port state, output, 3 bits: current state code.
REQ-008 Port in_mux_ctl, output, 2 bits: datapath register input select; 00 hold, 01 load external operands, 10 load rotation-step result, 11 load vectoring-step result.
REQ-009 Port counter_rst, output, 1 bit: 1 = external counter cleared to 0.
REQ-010 Port counter_hold, output, 1 bit: 1 = external counter frozen; 0 = counter increments each clk.

Function
REQ-011 State codes SHALL be IDLE=0, LOAD=1, ITER_ROT=2, ITER_VEC=3, DONE=4.
REQ-012 Outputs SHALL be Moore, decoded combinationally from the state register only.
REQ-013 Output decode SHALL be: IDLE mux 00/rst 1/hold 1; LOAD mux 01/rst 1/hold 1; ITER_ROT mux 10/rst 0/hold 0; ITER_VEC mux 11/rst 0/hold 0; DONE mux 00/rst 0/hold 1.
REQ-014 IDLE SHALL go to LOAD when start=1; otherwise it SHALL stay in IDLE.
REQ-015 In IDLE with start=1, cordic_mode SHALL be captured into an internal mode register; cordic_mode SHALL be ignored at all other times.
REQ-016 LOAD SHALL go unconditionally after one cycle to ITER_ROT if the captured mode=0, or to ITER_VEC if it is 1.
REQ-017 ITER_ROT and ITER_VEC SHALL stay put while counter[3]=0, and SHALL go to DONE on the edge where counter[3]=1 (counter >= 8, covering terminal value 8 and any 9-15).
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE, regardless of start.
REQ-019 start SHALL be ignored in LOAD, ITER_ROT, ITER_VEC and DONE; a new operation requires start=1 while in IDLE.
REQ-020 Unused state codes 5-7 SHALL decode outputs as IDLE and SHALL go to IDLE on the next edge.
REQ-021 Minimum latency from start sampled in IDLE to DONE SHALL be 3 edges (LOAD, ITER, DONE) when counter >= 8 on entry to ITER.

Reset
REQ-022 When reset_n=0 at a clk rising edge, the state SHALL become IDLE and the mode register SHALL become 0, overriding all other inputs, including mid-operation.
REQ-023 After reset, outputs SHALL be state=0, in_mux_ctl=00, counter_rst=1, counter_hold=1.

Structure
REQ-024 State codes, in_mux_ctl codes, and the terminal-count bit index (3) SHALL be defined in shared package cordic_pkg.
REQ-025 The block SHALL be a single module with no sub-modules: one state register, one mode register, a next-state block, and an output decoder.

Verification
REQ-026 Reset: reset_n=0 for one edge with random inputs -> state=0, in_mux_ctl=00, counter_rst=1, counter_hold=1.
REQ-027 Rotation run: mode=0, counter=0, start=1 for one edge, then 0 -> LOAD (mux 01), then ITER_ROT (mux 10, rst 0, hold 0) held for 4 cycles; counter=8 -> DONE (mux 00, hold 1) for one cycle -> IDLE.
REQ-028 Vectoring run: same sequence with mode=1 -> ITER_VEC with mux 11; counter=8 -> DONE -> IDLE.
REQ-029 Mode change mid-run: capture mode=0 at start, then set cordic_mode=1 during LOAD/ITER -> state stays ITER_ROT (2).
REQ-030 start held high throughout: sequence IDLE, LOAD, ITER, DONE, IDLE, then LOAD again; start during ITER has no effect.
REQ-031 Reset mid-ITER_VEC with counter=5 -> IDLE on the next edge; counter=12 in ITER -> DONE.
